clock_enable_controller: RTL and testbench

- Synthesizable run-control block for the SystemChip clocking scheme.
- Derives NUM_CH one-cycle clock-enable strobes from the single system clock, each using a programmable divisor.
- Sequences run, halt and single-step of the whole chip for debug.
- Sits between the clock source and the CPU/peripheral enable inputs. Channel 0 is the master (CPU) channel.

---
 rtl/clk_ctrl_pkg.sv | 18 +
 rtl/clk_en_divider.sv | 74 +++++++
 rtl/clock_enable_controller.sv | 115 +++++++++++
 tb/tb_clock_enable_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// rtl/clk_ctrl_pkg.sv - shared constants and FSM state encoding for clock_enable_controller
// Contents:
//   DIV_W_DEFAULT  default divisor width
//   CH_IDX_W       width of the channel index on the config port
//   run_state_e    run-control FSM states (RUN, DRAIN, HALTED, STEP)
package clk_ctrl_pkg;

   localparam int DIV_W_DEFAULT = 16;
   localparam int CH_IDX_W      = 3;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2,
      ST_STEP   = 2'd3
   } run_state_e;

endpackage

// File: rtl/clk_en_divider.sv
// rtl/clk_en_divider.sv - one programmable enable-strobe channel
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous reset, active-high
//   wr_en   in   load wr_div into the shadow divisor
//   wr_div  in   new divisor (0 behaves as 1)
//   cnt_en  in   counter advances only while high; frozen otherwise
//   strobe  out  registered one-cycle enable, period = active divisor
module clk_en_divider
   import clk_ctrl_pkg::*;
#(
   parameter int DIV_W     = DIV_W_DEFAULT,
   parameter int DIV_RESET = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [DIV_W-1:0] wr_div,
   input  logic             cnt_en,
   output logic             strobe
);

   // Counter reload value for a divisor; a zero divisor behaves as 1.
   function automatic logic [DIV_W-1:0] reload_of(input logic [DIV_W-1:0] d);
      return (d == '0) ? '0 : d - DIV_W'(1);
   endfunction

   localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DIV_RESET);
   localparam logic [DIV_W-1:0] RST_CNT = reload_of(RST_DIV);

   logic [DIV_W-1:0] shadow_q, shadow_d;
   logic [DIV_W-1:0] active_q, active_d;
   logic [DIV_W-1:0] count_q,  count_d;
   logic             strobe_q, strobe_d;

   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      count_d  = count_q;
      strobe_d = 1'b0;
      if (wr_en) begin
         shadow_d = wr_div;
      end
      if (cnt_en) begin
         if (count_q == '0) begin
            // Adopt the shadow only here, so a period is never cut short or
            // stretched. shadow_q (not shadow_d) is used: a write landing on
            // this same cycle waits for the following reload.
            active_d = shadow_q;
            count_d  = reload_of(active_d);
            strobe_d = 1'b1;
         end else begin
            count_d = count_q - DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= RST_DIV;
         active_q <= RST_DIV;
         count_q  <= RST_CNT;
         strobe_q <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         count_q  <= count_d;
         strobe_q <= strobe_d;
      end
   end

   assign strobe = strobe_q;

endmodule

// File: rtl/clock_enable_controller.sv
// rtl/clock_enable_controller.sv - per-channel clock-enable strobes with run/halt/single-step control
// Optional build macro: CLKCTRL_TICK_COUNT_EN (enables the 32-bit master tick counter)
// Ports:
//   Clock      in   system clock
//   Reset      in   asynchronous reset, active-high
//   CfgWrEn    in   divisor write strobe
//   CfgCh      in   target channel of the write (>= NUM_CH is ignored)
//   CfgDiv     in   new divisor value
//   HaltReq    in   level: 1 requests halt, 0 requests run
//   StepReq    in   pulse: one master tick while halted
//   ClkEn      out  per-channel enable strobes, channel 0 is the master
//   Halted     out  high while the FSM is in HALTED
//   TickCount  out  master strobe count (constant 0 without the macro)
module clock_enable_controller
   import clk_ctrl_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int DIV_W     = DIV_W_DEFAULT,
   parameter int DIV_RESET = 1
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                CfgWrEn,
   input  logic [CH_IDX_W-1:0] CfgCh,
   input  logic [DIV_W-1:0]    CfgDiv,
   input  logic                HaltReq,
   input  logic                StepReq,
   output logic [NUM_CH-1:0]   ClkEn,
   output logic                Halted,
   output logic [31:0]         TickCount
);

   run_state_e        state_q, state_d;
   logic [NUM_CH-1:0] wr_sel;
   logic [NUM_CH-1:0] strobe;
   logic              master_strobe;
   logic              cnt_en;

   assign master_strobe = strobe[0];

   always_comb begin
      wr_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         wr_sel[i] = CfgWrEn && (CfgCh == CH_IDX_W'(i));
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (HaltReq) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!HaltReq)          state_d = ST_RUN;
            else if (master_strobe) state_d = ST_HALTED;
         end
         ST_HALTED: begin
            if (!HaltReq)    state_d = ST_RUN;
            else if (StepReq) state_d = ST_STEP;
         end
         ST_STEP: begin
            // Extra StepReq pulses are simply not looked at here.
            if (master_strobe) state_d = HaltReq ? ST_HALTED : ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Counters freeze on the cycle that enters HALTED as well as in HALTED
   // itself, so no strobe is registered into the halted period and the first
   // strobe after leaving HALTED comes at least one cycle after the exit.
   assign cnt_en = (state_q != ST_HALTED) && (state_d != ST_HALTED);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state_q <= ST_RUN;
      else       state_q <= state_d;
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_en_divider #(
         .DIV_W     (DIV_W),
         .DIV_RESET (DIV_RESET)
      ) u_div (
         .clk    (Clock),
         .rst    (Reset),
         .wr_en  (wr_sel[i]),
         .wr_div (CfgDiv),
         .cnt_en (cnt_en),
         .strobe (strobe[i])
      );
   end

   assign ClkEn  = strobe;
   assign Halted = (state_q == ST_HALTED);

`ifdef CLKCTRL_TICK_COUNT_EN
   logic [31:0] tick_q, tick_d;

   always_comb begin
      tick_d = tick_q;
      if (master_strobe) tick_d = tick_q + 32'd1;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) tick_q <= '0;
      else       tick_q <= tick_d;
   end

   assign TickCount = tick_q;
`else
   assign TickCount = 32'd0;
`endif

endmodule

// File: tb/tb_clock_enable_controller.sv
// tb/tb_clock_enable_controller.sv - self-checking bench for clock_enable_controller
module tb_clock_enable_controller;

   localparam int NUM_CH = 2;
   localparam int DIV_W  = 16;

   logic              Clock;
   logic              Reset;
   logic              CfgWrEn;
   logic [2:0]        CfgCh;
   logic [DIV_W-1:0]  CfgDiv;
   logic              HaltReq;
   logic              StepReq;
   logic [NUM_CH-1:0] ClkEn;
   logic              Halted;
   logic [31:0]       TickCount;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   clock_enable_controller #(
      .NUM_CH    (NUM_CH),
      .DIV_W     (DIV_W),
      .DIV_RESET (1)
   ) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .CfgWrEn   (CfgWrEn),
      .CfgCh     (CfgCh),
      .CfgDiv    (CfgDiv),
      .HaltReq   (HaltReq),
      .StepReq   (StepReq),
      .ClkEn     (ClkEn),
      .Halted    (Halted),
      .TickCount (TickCount)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic step_clk;
      @(posedge Clock);
      #1;
   endtask

   task automatic wait_master(output bit ok);
      int n;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 20) begin
         step_clk();
         n++;
         if (ClkEn[0]) ok = 1'b1;
      end
   endtask

   task automatic test_reset;
      logic [31:0] exp, obs;
      Reset = 1'b1; CfgWrEn = 1'b0; CfgCh = '0; CfgDiv = '0;
      HaltReq = 1'b0; StepReq = 1'b0;
      repeat (3) step_clk();
      checks++;
      if (ClkEn !== 2'b00) begin errors++; $display("FAIL reset_clken: got %b expected 00", ClkEn); end
      checks++;
      if (Halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", Halted); end
      checks++;
      if (TickCount !== 32'd0) begin errors++; $display("FAIL reset_tick: got %h expected 0", TickCount); end
      Reset = 1'b0;
      for (int k = 1; k <= 5; k++) exp_q.push_back({29'd0, 1'b0, 2'b11});
      for (int k = 1; k <= 5; k++) begin
         step_clk();
         exp = exp_q.pop_front();
         obs = {29'd0, Halted, ClkEn};
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL div1_run cyc%0d: got %h expected %h", k, obs, exp); end
      end
   endtask

   task automatic test_div_change;
      logic [31:0] exp, obs;
      bit e0, e1;
      CfgWrEn = 1'b1; CfgCh = 3'd0; CfgDiv = 16'd4;
      for (int k = 1; k <= 16; k++) begin
         e0 = (k == 1) || ((k - 2) % 4 == 0);
         e1 = (k <= 2) || ((k - 3) % 3 == 0);
         exp_q.push_back({30'd0, e1, e0});
      end
      for (int k = 1; k <= 16; k++) begin
         step_clk();
         exp = exp_q.pop_front();
         obs = {30'd0, ClkEn};
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL div_change cyc%0d: got %h expected %h", k, obs, exp); end
         if (k == 1) begin CfgCh = 3'd1; CfgDiv = 16'd3; end
         if (k == 2) begin CfgCh = 3'd5; CfgDiv = 16'd7; end
         if (k == 3) CfgWrEn = 1'b0;
      end
   endtask

   task automatic test_halt;
      logic [31:0] exp, obs;
      bit ok;
      wait_master(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL halt_sync: got no ch0 strobe expected one within 20 cycles"); end
      exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      exp_q.push_back(32'h1); exp_q.push_back(32'h2);
      for (int k = 1; k <= 5; k++) begin
         step_clk();
         exp = exp_q.pop_front();
         obs = {30'd0, Halted, ClkEn[0]};
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL drain cyc%0d: got %h expected %h", k, obs, exp); end
         if (k == 1) HaltReq = 1'b1;
      end
      for (int k = 1; k <= 20; k++) begin
         step_clk();
         obs = {29'd0, Halted, ClkEn};
         checks++;
         if (obs !== 32'h4) begin errors++; $display("FAIL halted_quiet cyc%0d: got %h expected 4", k, obs); end
      end
   endtask

   task automatic test_step;
      logic [31:0] exp, obs;
      int jj, strobes;
      strobes = 0;
      for (int j = 1; j <= 30; j++) begin
         jj = (j - 1) % 10 + 1;
         exp_q.push_back({30'd0, (jj >= 6), (jj == 5)});
      end
      StepReq = 1'b1;
      for (int j = 1; j <= 30; j++) begin
         step_clk();
         exp = exp_q.pop_front();
         obs = {30'd0, Halted, ClkEn[0]};
         if (ClkEn[0]) strobes++;
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL step cyc%0d: got %h expected %h", j, obs, exp); end
         StepReq = (j == 2) || (j == 10) || (j == 20);
      end
      checks++;
      if (strobes != 3) begin errors++; $display("FAIL step_count: got %0d expected 3", strobes); end
   endtask

   task automatic test_resume;
      logic [31:0] exp, obs;
      for (int k = 1; k <= 9; k++) exp_q.push_back({31'd0, (k == 5) || (k == 9)});
      HaltReq = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         step_clk();
         exp = exp_q.pop_front();
         obs = {30'd0, Halted, ClkEn[0]};
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL resume cyc%0d: got %h expected %h", k, obs, exp); end
      end
   endtask

   task automatic test_reset_in_step;
      logic [31:0] exp, obs;
      int n;
      HaltReq = 1'b1;
      n = 0;
      while (!Halted && n < 20) begin step_clk(); n++; end
      checks++;
      if (Halted !== 1'b1) begin errors++; $display("FAIL rst_step_halt: got %b expected 1 within 20 cycles", Halted); end
      StepReq = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step_clk();
         StepReq = 1'b0;
      end
      checks++;
      if (ClkEn[0] !== 1'b1) begin errors++; $display("FAIL rst_step_strobe: got %b expected 1", ClkEn[0]); end
      Reset = 1'b1;
      HaltReq = 1'b0;
      #2;
      checks++;
      if (ClkEn !== 2'b00) begin errors++; $display("FAIL async_rst_clken: got %b expected 00", ClkEn); end
      checks++;
      if (Halted !== 1'b0) begin errors++; $display("FAIL async_rst_halted: got %b expected 0", Halted); end
      checks++;
      if (TickCount !== 32'd0) begin errors++; $display("FAIL async_rst_tick: got %h expected 0", TickCount); end
      repeat (2) step_clk();
      Reset = 1'b0;
      for (int k = 1; k <= 4; k++) exp_q.push_back(32'h3);
      for (int k = 1; k <= 4; k++) begin
         step_clk();
         exp = exp_q.pop_front();
         obs = {29'd0, Halted, ClkEn};
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL post_rst_run cyc%0d: got %h expected %h", k, obs, exp); end
      end
   endtask

   task automatic test_tick;
      logic [31:0] exp;
`ifdef CLKCTRL_TICK_COUNT_EN
      Reset = 1'b1;
      step_clk();
      Reset = 1'b0;
      for (int k = 1; k <= 11; k++) exp_q.push_back(32'(k - 1));
      for (int k = 1; k <= 11; k++) begin
         step_clk();
         exp = exp_q.pop_front();
         checks++;
         if (TickCount !== exp) begin errors++; $display("FAIL tick cyc%0d: got %0d expected %0d", k, TickCount, exp); end
      end
      force dut.tick_q = 32'hFFFF_FFFF;
      #2;
      release dut.tick_q;
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd1);
      for (int k = 1; k <= 2; k++) begin
         step_clk();
         exp = exp_q.pop_front();
         checks++;
         if (TickCount !== exp) begin errors++; $display("FAIL tick_wrap cyc%0d: got %h expected %h", k, TickCount, exp); end
      end
`else
      for (int k = 1; k <= 10; k++) exp_q.push_back(32'd0);
      for (int k = 1; k <= 10; k++) begin
         step_clk();
         exp = exp_q.pop_front();
         checks++;
         if (TickCount !== exp) begin errors++; $display("FAIL tick_off cyc%0d: got %h expected %h", k, TickCount, exp); end
      end
`endif
   endtask

   initial begin
      test_reset();
      test_div_change();
      test_halt();
      test_step();
      test_resume();
      test_reset_in_step();
      test_tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
